// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: issues four byte reads per instruction to a synchronous
// byte ROM, assembles them little-endian and hands the word to decode over valid/ready.
module instr_fetch_seq #(
    parameter int                  A_length = 12,
    parameter logic [A_length-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                redirect_valid,
    input  logic [A_length-1:0] redirect_pc,
    output logic                mem_en,
    output logic [A_length-1:0] mem_addr,
    input  logic [7:0]          mem_rdata,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [31:0]         instr,
    output logic [A_length-1:0] instr_pc
);

    typedef enum logic [1:0] {
        ISSUE,
        DRAIN,
        VALID
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [A_length-1:0] pc;
    logic [A_length-1:0] pc_next;
    logic [1:0]          issue_cnt;
    logic [1:0]          issue_cnt_next;
    logic                rx_pend;
    logic [1:0]          rx_idx;
    logic [3:0][7:0]     lanes;
    logic                issuing;

    assign issuing = (state == ISSUE);

    // Gating with rst_n keeps the ROM idle for the whole reset window.
    assign mem_en   = issuing && rst_n;
    assign mem_addr = issuing ? {pc[A_length-1:2], issue_cnt} : pc;

    assign instr_valid = (state == VALID);
    assign instr       = lanes;
    assign instr_pc    = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ISSUE;
            pc        <= RESET_PC;
            issue_cnt <= 2'd0;
            rx_pend   <= 1'b0;
            rx_idx    <= 2'd0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            issue_cnt <= issue_cnt_next;
            rx_pend   <= mem_en && !redirect_valid;
            rx_idx    <= issue_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lanes <= '0;
        end else if (rx_pend) begin
            lanes[rx_idx] <= mem_rdata;
        end
    end

    // Redirect overrides the per-state decision, including a same-edge handshake.
    always_comb begin
        state_next     = state;
        pc_next        = pc;
        issue_cnt_next = issue_cnt;
        unique case (state)
            ISSUE: begin
                issue_cnt_next = issue_cnt + 2'd1;
                if (issue_cnt == 2'd3) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = VALID;
            end
            VALID: begin
                if (instr_ready) begin
                    pc_next        = pc + A_length'(4);
                    issue_cnt_next = 2'd0;
                    state_next     = ISSUE;
                end
            end
            default: begin
                state_next = ISSUE;
            end
        endcase
        if (redirect_valid) begin
            pc_next        = {redirect_pc[A_length-1:2], 2'b00};
            issue_cnt_next = 2'd0;
            state_next     = ISSUE;
        end
    end

endmodule
